// File: rtl/sample_readout.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sample_readout
// Purpose  : Drains a logic-analyzer sample window over the 16-bit daisy-chain
//            register bus (one outstanding read at a time) and serializes each
//            returned word as two bytes, MSB first, over a valid/ready link.
// Options  : READOUT_TIMEOUT_EN - when defined, a read that gets no matching
//            response within TIMEOUT WAIT cycles abandons the run and pulses
//            error. When undefined, WAIT waits forever and error is tied 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module sample_readout #(
    parameter int BASE_ADDR = 0,
    parameter int COUNT     = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid,
    input  logic        byte_ready
);

    localparam int                 c_IDX_W    = $clog2(COUNT + 1);
    localparam logic [15:0]        c_BASE16   = 16'(BASE_ADDR);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(COUNT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_SEND_HI = 3'd3,
        S_SEND_LO = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             r_state, w_next;
    logic [c_IDX_W-1:0] r_idx, w_idx_next;
    logic [15:0]        r_word, w_word_next;
    logic [15:0]        w_iss_addr;
    logic               w_match;
    logic               w_unused;

    logic [15:0]        r_addr_o;
    logic               r_valid_o;
    logic [7:0]         r_byte;
    logic               r_byte_valid;

    // The address of the read currently in flight; addr_o itself returns to 0
    // after ISSUE, so responses are matched against this instead.
    assign w_iss_addr = c_BASE16 + 16'(r_idx);
    assign w_match    = valid_i && !rw_i && (addr_i == w_iss_addr);

`ifdef READOUT_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_wait_cnt;
    logic              w_timeout;
    logic              w_err_next;
    logic              r_error;

    // Counter holds k-1 during the k-th WAIT cycle, so the TIMEOUT-th WAIT
    // cycle without a match is the last one.
    assign w_timeout = (r_wait_cnt == c_TO_LAST);

    // WAIT-cycle counter, cleared whenever the FSM is not waiting.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT) r_wait_cnt <= '0;
        else                          r_wait_cnt <= r_wait_cnt + c_TO_ONE;
    end

    // One-cycle error pulse, aligned with the return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) r_error <= 1'b0;
        else     r_error <= w_err_next;
    end

    assign error    = r_error;
    assign w_unused = ^wdata_i;
`else
    assign error    = 1'b0;
    assign w_unused = ^{wdata_i, 32'(TIMEOUT)};
`endif

    // Next-state, next-index and captured-word logic.
    always_comb begin
        w_next      = r_state;
        w_idx_next  = r_idx;
        w_word_next = r_word;
`ifdef READOUT_TIMEOUT_EN
        w_err_next  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_ISSUE;
                    w_idx_next = '0;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_match) begin
                    w_word_next = rdata_i;
                    w_next      = S_SEND_HI;
                end
`ifdef READOUT_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next     = S_IDLE;
                    w_err_next = 1'b1;
                end
`endif
            end
            S_SEND_HI: begin
                if (byte_ready) w_next = S_SEND_LO;
            end
            S_SEND_LO: begin
                if (byte_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_next = S_DONE;
                    end else begin
                        w_idx_next = r_idx + c_IDX_ONE;
                        w_next     = S_ISSUE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, index and word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_word  <= w_word_next;
        end
    end

    // Output registers are loaded from the next state so they line up with
    // the state they describe; byte_o keeps its value outside SEND states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_o     <= '0;
            r_valid_o    <= 1'b0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_valid_o    <= (w_next == S_ISSUE);
            r_addr_o     <= (w_next == S_ISSUE) ? (c_BASE16 + 16'(w_idx_next)) : 16'h0000;
            r_byte_valid <= (w_next == S_SEND_HI) || (w_next == S_SEND_LO);
            if (w_next == S_SEND_HI)      r_byte <= w_word_next[15:8];
            else if (w_next == S_SEND_LO) r_byte <= w_word_next[7:0];
        end
    end

    assign addr_o     = r_addr_o;
    assign valid_o    = r_valid_o;
    assign rw_o       = 1'b0;
    assign wdata_o    = 16'h0000;
    assign rdata_o    = 16'h0000;
    assign byte_o     = r_byte;
    assign byte_valid = r_byte_valid;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sample_readout.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_sample_readout
// Purpose  : Directed self-checking bench for sample_readout. Instance 0 is a
//            single-word reader at address 0; instance 1 reads four words at
//            0x10. Each instance has a two-cycle chain responder; instance 1
//            can also have its return path overridden to inject traffic.
// Options  : READOUT_TIMEOUT_EN enables the timeout scenario.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sample_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic        start      [2];
    logic        byte_ready;
    logic        busy       [2];
    logic        done       [2];
    logic        error      [2];
    logic        rw_o       [2];
    logic        valid_o    [2];
    logic        byte_valid [2];
    logic [15:0] addr_o     [2];
    logic [15:0] wdata_o    [2];
    logic [15:0] rdata_o    [2];
    logic [15:0] addr_i     [2];
    logic [15:0] wdata_i    [2];
    logic [15:0] rdata_i    [2];
    logic        rw_i       [2];
    logic        valid_i    [2];
    logic [7:0]  byte_o     [2];

    // responder pipeline and injection controls
    logic        s1_v [2], s1_rw [2], s2_v [2], s2_rw [2];
    logic [15:0] s1_a [2], s2_a [2], s2_d [2];
    logic        resp_en;
    logic [15:0] data_base;
    logic        inj_en, inj_v, inj_rw;
    logic [15:0] inj_a, inj_d;

    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    sample_readout #(.BASE_ADDR(0), .COUNT(1), .TIMEOUT(8)) u_single (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .error(error[0]), .addr_o(addr_o[0]), .wdata_o(wdata_o[0]), .rdata_o(rdata_o[0]),
        .rw_o(rw_o[0]), .valid_o(valid_o[0]), .addr_i(addr_i[0]), .wdata_i(wdata_i[0]),
        .rdata_i(rdata_i[0]), .rw_i(rw_i[0]), .valid_i(valid_i[0]), .byte_o(byte_o[0]),
        .byte_valid(byte_valid[0]), .byte_ready(byte_ready)
    );

    sample_readout #(.BASE_ADDR(16'h0010), .COUNT(4), .TIMEOUT(8)) u_multi (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .error(error[1]), .addr_o(addr_o[1]), .wdata_o(wdata_o[1]), .rdata_o(rdata_o[1]),
        .rw_o(rw_o[1]), .valid_o(valid_o[1]), .addr_i(addr_i[1]), .wdata_i(wdata_i[1]),
        .rdata_i(rdata_i[1]), .rw_i(rw_i[1]), .valid_i(valid_i[1]), .byte_o(byte_o[1]),
        .byte_valid(byte_valid[1]), .byte_ready(byte_ready)
    );

    // Two-cycle sample memory model: read data = data_base + addr * 0x0101.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                s1_v[k] <= 1'b0; s1_rw[k] <= 1'b0; s1_a[k] <= '0;
                s2_v[k] <= 1'b0; s2_rw[k] <= 1'b0; s2_a[k] <= '0; s2_d[k] <= '0;
            end else begin
                s1_v[k]  <= valid_o[k];
                s1_rw[k] <= rw_o[k];
                s1_a[k]  <= addr_o[k];
                s2_v[k]  <= s1_v[k] & resp_en;
                s2_rw[k] <= s1_rw[k];
                s2_a[k]  <= s1_a[k];
                s2_d[k]  <= s1_rw[k] ? 16'h0000 : 16'(data_base + s1_a[k] * 16'h0101);
            end
        end
    end

    // Chain tail: responder output, or injected traffic on instance 1.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            valid_i[k] = s2_v[k];
            rw_i[k]    = s2_rw[k];
            addr_i[k]  = s2_a[k];
            rdata_i[k] = s2_d[k];
            wdata_i[k] = 16'h0000;
            if (k == 1 && inj_en) begin
                valid_i[k] = inj_v;
                rw_i[k]    = inj_rw;
                addr_i[k]  = inj_a;
                rdata_i[k] = inj_d;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start[0] = 1'b1; start[1] = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (valid_o[0] !== 1'b0 || valid_o[1] !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_request: valid_o=%b/%b expected 0/0", valid_o[0], valid_o[1]);
        end
        rst = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: busy=%b/%b expected 0/0", busy[0], busy[1]);
        end
        n_cmp++;
        if ({addr_o[1], wdata_o[1], rdata_o[1], rw_o[1], valid_o[1]} !== 50'h0) begin
            n_bad++; $display("FAIL reset_bus: addr=%h wdata=%h rdata=%h rw=%b valid=%b expected all 0",
                              addr_o[1], wdata_o[1], rdata_o[1], rw_o[1], valid_o[1]);
        end
        n_cmp++;
        if ({byte_o[1], byte_valid[1], done[1], error[1]} !== 11'h0) begin
            n_bad++; $display("FAIL reset_byte_flags: byte_o=%h byte_valid=%b done=%b error=%b expected 0",
                              byte_o[1], byte_valid[1], done[1], error[1]);
        end
    endtask

    // COUNT=1 at address 0, data 0xA55A, byte_ready held high.
    task automatic test_single();
        int         nb, nreq, done_k;
        logic [7:0] b [2];
        nb = 0; nreq = 0; done_k = 0; b[0] = '0; b[1] = '0;
        data_base = 16'hA55A; resp_en = 1'b1; byte_ready = 1'b1;
        start[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start[0] = 1'b0;
                n_cmp++;
                if ({valid_o[0], rw_o[0], addr_o[0], wdata_o[0], rdata_o[0], busy[0]} !== {1'b1, 1'b0, 48'h0, 1'b1}) begin
                    n_bad++; $display("FAIL single_issue: valid=%b rw=%b addr=%h wd=%h rd=%h busy=%b expected 1 0 0000 0000 0000 1",
                                      valid_o[0], rw_o[0], addr_o[0], wdata_o[0], rdata_o[0], busy[0]);
                end
            end
            if (valid_o[0]) nreq++;
            if (byte_valid[0] && byte_ready) begin
                if (nb < 2) b[nb] = byte_o[0];
                nb++;
            end
            if (done[0] && done_k == 0) done_k = k;
            // start during the done cycle must be ignored
            if (k == 6) start[0] = 1'b1;
            if (k == 7) begin
                start[0] = 1'b0;
                n_cmp++;
                if (busy[0] !== 1'b0 || valid_o[0] !== 1'b0) begin
                    n_bad++; $display("FAIL single_start_at_done: busy=%b valid=%b expected 0 0", busy[0], valid_o[0]);
                end
            end
        end
        n_cmp++;
        if (nreq !== 1) begin n_bad++; $display("FAIL single_nreq: got %0d expected 1", nreq); end
        n_cmp++;
        if (nb !== 2 || b[0] !== 8'hA5 || b[1] !== 8'h5A) begin
            n_bad++; $display("FAIL single_bytes: count=%0d bytes=%h %h expected 2 a5 5a", nb, b[0], b[1]);
        end
        n_cmp++;
        if (done_k !== 6) begin n_bad++; $display("FAIL single_done_cycle: got %0d expected 6", done_k); end
    endtask

    // COUNT=4 at 0x10 with a fixed irregular byte_ready pattern.
    task automatic test_multi();
        logic [31:0] pat;
        logic [7:0]  exp_b [8];
        logic [7:0]  got   [8];
        logic [7:0]  held;
        logic        stalled;
        int          nb, nreq, ndone, after_done, cyc;
        pat = 32'b1011_0010_1101_0110_0011_1010_1001_1100;
        exp_b = '{8'h22, 8'h44, 8'h23, 8'h45, 8'h24, 8'h46, 8'h25, 8'h47};
        for (int i = 0; i < 8; i++) got[i] = '0;
        nb = 0; nreq = 0; ndone = 0; after_done = 0; cyc = 0; stalled = 1'b0; held = '0;
        data_base = 16'h1234; resp_en = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        while (cyc < 300 && after_done < 3) begin
            if (valid_o[1]) begin
                n_cmp++;
                if (addr_o[1] !== 16'(16'h0010 + nreq)) begin
                    n_bad++; $display("FAIL multi_addr: got %h expected %h", addr_o[1], 16'(16'h0010 + nreq));
                end
                nreq++;
            end
            if (stalled) begin
                n_cmp++;
                if (byte_valid[1] !== 1'b1 || byte_o[1] !== held) begin
                    n_bad++; $display("FAIL multi_hold: byte_valid=%b byte_o=%h expected 1 %h", byte_valid[1], byte_o[1], held);
                end
            end
            if (done[1]) ndone++;
            if (ndone > 0) after_done++;
            byte_ready = pat[cyc % 32];
            if (byte_valid[1] && byte_ready) begin
                if (nb < 8) got[nb] = byte_o[1];
                nb++;
            end
            stalled = byte_valid[1] && !byte_ready;
            held    = byte_o[1];
            cyc++;
            @(negedge clk);
        end
        byte_ready = 1'b1;
        n_cmp++;
        if (ndone !== 1) begin n_bad++; $display("FAIL multi_done_count: got %0d expected 1", ndone); end
        n_cmp++;
        if (nreq !== 4 || nb !== 8) begin
            n_bad++; $display("FAIL multi_counts: requests=%0d bytes=%0d expected 4 8", nreq, nb);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL multi_byte%0d: got %h expected %h", i, got[i], exp_b[i]);
            end
        end
    endtask

    // Write to the issued address and a read to 0x99 must not be captured.
    task automatic test_nonmatch();
        resp_en = 1'b0; inj_en = 1'b1; inj_v = 1'b0; byte_ready = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        inj_v = 1'b1; inj_rw = 1'b1; inj_a = 16'h0010; inj_d = 16'hDEAD;
        @(negedge clk);
        n_cmp++;
        if (byte_valid[1] !== 1'b0) begin n_bad++; $display("FAIL nonmatch_write: byte_valid=%b expected 0", byte_valid[1]); end
        inj_rw = 1'b0; inj_a = 16'h0099; inj_d = 16'hBAD0;
        @(negedge clk);
        n_cmp++;
        if (byte_valid[1] !== 1'b0) begin n_bad++; $display("FAIL nonmatch_addr: byte_valid=%b expected 0", byte_valid[1]); end
        inj_a = 16'h0010; inj_d = 16'h5AC3;
        @(negedge clk);
        inj_v = 1'b0;
        n_cmp++;
        if (byte_valid[1] !== 1'b1 || byte_o[1] !== 8'h5A) begin
            n_bad++; $display("FAIL nonmatch_hi: byte_valid=%b byte_o=%h expected 1 5a", byte_valid[1], byte_o[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (byte_valid[1] !== 1'b1 || byte_o[1] !== 8'hC3) begin
            n_bad++; $display("FAIL nonmatch_lo: byte_valid=%b byte_o=%h expected 1 c3", byte_valid[1], byte_o[1]);
        end
        inj_en = 1'b0; resp_en = 1'b1;
        do_reset();
    endtask

    // Reset during SEND_HI of the second word, then restart from BASE_ADDR.
    task automatic test_reset_midrun();
        int nbv;
        logic found;
        nbv = 0; found = 1'b0;
        data_base = 16'h1234; resp_en = 1'b1; byte_ready = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (byte_valid[1]) begin
                nbv++;
                if (nbv == 3) found = 1'b1;
            end
            if (!found) @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL midrun_reach_word2: byte cycles seen %0d expected 3 within 60 cycles", nbv);
        end else begin
            if (byte_o[1] !== 8'h23) begin
                n_bad++; $display("FAIL midrun_word2_hi: got %h expected 23", byte_o[1]);
            end
            rst = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({byte_valid[1], busy[1], valid_o[1], byte_o[1]} !== 11'h0) begin
                n_bad++; $display("FAIL midrun_reset: byte_valid=%b busy=%b valid=%b byte_o=%h expected 0",
                                  byte_valid[1], busy[1], valid_o[1], byte_o[1]);
            end
            rst = 1'b0; start[1] = 1'b1;
            @(negedge clk);
            start[1] = 1'b0;
            n_cmp++;
            if (valid_o[1] !== 1'b1 || addr_o[1] !== 16'h0010) begin
                n_bad++; $display("FAIL midrun_restart: valid=%b addr=%h expected 1 0010", valid_o[1], addr_o[1]);
            end
        end
        do_reset();
    endtask

`ifdef READOUT_TIMEOUT_EN
    // No response: eight WAIT cycles, then an error pulse with busy low.
    task automatic test_timeout();
        int   nwait;
        logic seen_err, seen_byte;
        nwait = 0; seen_err = 1'b0; seen_byte = 1'b0;
        resp_en = 1'b0;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int c = 0; c < 40 && !seen_err; c++) begin
            @(negedge clk);
            if (byte_valid[1]) seen_byte = 1'b1;
            if (error[1]) seen_err = 1'b1;
            else if (busy[1]) nwait++;
        end
        n_cmp++;
        if (!seen_err || nwait !== 8) begin
            n_bad++; $display("FAIL timeout_error: seen=%b wait_cycles=%0d expected 1 8", seen_err, nwait);
        end
        n_cmp++;
        if (busy[1] !== 1'b0 || done[1] !== 1'b0 || seen_byte) begin
            n_bad++; $display("FAIL timeout_abandon: busy=%b done=%b bytes=%b expected 0 0 0", busy[1], done[1], seen_byte);
        end
        @(negedge clk);
        n_cmp++;
        if (error[1] !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse: error=%b expected 0", error[1]); end
        resp_en = 1'b1;
    endtask
`endif

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start[0] = 1'b0; start[1] = 1'b0; byte_ready = 1'b1;
        resp_en = 1'b1; data_base = 16'h0000;
        inj_en = 1'b0; inj_v = 1'b0; inj_rw = 1'b0; inj_a = 16'h0000; inj_d = 16'h0000;
        test_reset();
        test_single();
        test_multi();
        test_nonmatch();
        test_reset_midrun();
`ifdef READOUT_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sample_readout.md
# sample_readout

Bus initiator that drains a logic analyzer sample window over the 16-bit daisy-chain register bus and serializes the words into a byte stream for the host link transmitter. On `start` it issues `COUNT` sequential single-word reads at `BASE_ADDR`, `BASE_ADDR+1`, … and waits for each read to return around the chain. It emits each returned `rdata` as two bytes, MSB first, through a valid/ready handshake. It sits at the head of the bus chain, ahead of the sample memory and other responders.

## Interface
Parameters:
- `BASE_ADDR`, default 0: bus address of the first sample word.
- `COUNT`, default 16: number of words read per run, ≥1, ≤65536.
- `TIMEOUT`, default 255: maximum WAIT cycles per read; used only with `READOUT_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock. Every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run. Sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last byte of a run is accepted.
- `error` out 1: one-cycle pulse when a read times out. Only with the macro; otherwise tied 0.
- `addr_o`, `wdata_o`, `rdata_o` out 16 each: bus request fields, registered.
- `rw_o`, `valid_o` out 1 each: bus request fields, registered.
- `addr_i`, `wdata_i`, `rdata_i` in 16 each: bus fields returning from the chain tail.
- `rw_i`, `valid_i` in 1 each: bus fields returning from the chain tail.
- `byte_o` out 8: outgoing byte.
- `byte_valid` out 1: `byte_o` is valid.
- `byte_ready` in 1: the sink accepts the byte this cycle.

## Operation
- States are IDLE, ISSUE, WAIT, SEND_HI, SEND_LO, DONE.
- IDLE
  - `start` → ISSUE, with `idx` cleared to 0.
- ISSUE, lasts exactly one cycle:
  - `valid_o` is 1, `rw_o` is 0.
  - `addr_o` = (`BASE_ADDR` + `idx`) mod 2^16.
  - `wdata_o` and `rdata_o` are 0.
  - Next state is WAIT.
- WAIT
  - A response matches when `valid_i` & !`rw_i` & `addr_i` == the issued address.
  - On a match, latch `rdata_i` into `word` and go to SEND_HI.
  - Returning transactions that do not match are ignored.
- SEND_HI
  - `byte_o` = `word[15:8]`, `byte_valid` = 1.
  - On `byte_ready` → SEND_LO.
- SEND_LO
  - `byte_o` = `word[7:0]`, `byte_valid` = 1.
  - On `byte_ready`: if `idx` == `COUNT`-1 → DONE; otherwise `idx`+1 and → ISSUE.
- DONE
  - `done` = 1 for one cycle, then → IDLE.
- `idx` width is $clog2(`COUNT`+1). Address arithmetic wraps at 16 bits.
- Outside ISSUE, all bus outputs are 0.
- Outside SEND states, `byte_valid` = 0. `byte_o` holds its last value.
- `start` while `busy` is ignored; no queuing.
- Exactly one read is outstanding at a time. A new ISSUE never occurs before the previous response is consumed.
- Reset, including mid-run: state → IDLE, `idx` = 0, `word` = 0.
  - All outputs are 0 after the reset edge: bus fields, `byte_o`, `byte_valid`, `busy`, `done`, `error`.
  - A response that arrives after reset is ignored.

## Timing
- `start` sampled high at edge N: `valid_o` and `busy` are high during cycle N+1.
- The response is captured at the first matching edge M. `byte_valid` is high from M+1.
- `byte_valid` and `byte_o` are held stable until `byte_ready`. Each byte transfers on an edge where `byte_valid` & `byte_ready` are both high.
- Minimum cost per word is 1 issue cycle + chain latency + 2 byte cycles.
  - Example: a single sample memory in the chain adds 2 cycles of latency, giving 5 cycles per word with `byte_ready` held high.
- `done` is high in the cycle after the final low-byte handshake. `busy` is low the cycle after that.
- A `start` in the same cycle as `done` is ignored.
- `start` and `rst` together: reset wins.

## Configuration
- Macro: `READOUT_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT, cleared on entry.
  - If it reaches `TIMEOUT` with no match, `error` pulses for one cycle and the state → IDLE. No `done` pulse; the run is abandoned.
- Undefined:
  - WAIT waits indefinitely.
  - No counter logic is built; `error` is constant 0.

## Test plan
- Reset behaviour: hold `rst` 2 cycles, then release → every output is 0 and `busy` is 0. With `start`=1 during reset, no bus request appears.
- Single read: `BASE_ADDR`=0, `COUNT`=1, model responder with 2-cycle latency returning `rdata_i`=0xA55A. Pulse `start` → one read at `addr_o`=0; bytes 0xA5 then 0x5A; `done` high 6 cycles after `start` is sampled.
- Multi-word read with backpressure: `COUNT`=4, `BASE_ADDR`=0x10, random `byte_ready` → requests at 0x10–0x13 in order; 8 bytes emitted; each byte held stable until accepted; exactly one `done`.
- Non-matching traffic: during WAIT inject a write to the same address and a read to 0x99 → both ignored; only the real read response is captured.
- Reset mid-run: assert `rst` in SEND_HI of word 2 → IDLE with `byte_valid`=0 on the next edge; a fresh `start` restarts at `BASE_ADDR`.
- Timeout (macro defined, `TIMEOUT`=8): responder never answers → `error` pulses at WAIT cycle 8; no bytes are emitted; `busy` drops.
